aes_core_sequencer: RTL and testbench

Host-side initiator for the iterative AES core's load/busy interface (clk, load_i, key_i, data_i, data_o, busy_o). It accepts one encryption request on a valid/ready port and drives a single-cycle load pulse with key and plaintext. It then tracks the core's busy window, captures the ciphertext when busy falls, and returns it on a valid/ready response port. Sits between the capture/USB register block and the AES core, replacing hand-timed load strobes.

---
 rtl/aes_core_sequencer.sv | 167 ++++++++++++++++
 tb/tb_aes_core_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_core_sequencer.sv
// Host-side sequencer for the iterative AES core: takes one request, pulses load,
// tracks the busy window with timeouts and returns the ciphertext on a response port.
module aes_core_sequencer #(
  parameter int unsigned KEY_W     = 128,
  parameter int unsigned DATA_W    = 128,
  parameter int unsigned BUSY_WAIT = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [KEY_W-1:0]  req_key_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_timeout_o,
  output logic              core_load_o,
  output logic [KEY_W-1:0]  core_key_o,
  output logic [DATA_W-1:0] core_data_o,
  input  logic [DATA_W-1:0] core_data_i,
  input  logic              core_busy_i,
  output logic [CNT_W-1:0]  done_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o
);

  localparam int unsigned MaxWait = (BUSY_WAIT > TIMEOUT) ? BUSY_WAIT : TIMEOUT;
  localparam int unsigned TimerW  = (MaxWait > 1) ? $clog2(MaxWait) : 1;
  localparam logic [TimerW-1:0] BusyLast = TimerW'(BUSY_WAIT - 1);
  localparam logic [TimerW-1:0] RunLast  = TimerW'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StWaitBusy, StRun, StResp} state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                core_load_q, core_load_d;
  logic [KEY_W-1:0]    core_key_q, core_key_d;
  logic [DATA_W-1:0]   core_data_q, core_data_d;
  logic [CNT_W-1:0]    done_cnt_q, done_cnt_d;
  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d;
  logic                accept;

  assign accept = (state_q == StIdle) && req_valid_i && req_ready_q;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_timeout_q <= 1'b0;
      core_load_q   <= 1'b0;
      core_key_q    <= '0;
      core_data_q   <= '0;
      done_cnt_q    <= '0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_timeout_q <= rsp_timeout_d;
      core_load_q   <= core_load_d;
      core_key_q    <= core_key_d;
      core_data_q   <= core_data_d;
      done_cnt_q    <= done_cnt_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      StIdle: begin
        if (accept) state_d = StLoad;
      end
      StLoad: begin
        timer_d = '0;
        state_d = StWaitBusy;
      end
      StWaitBusy: begin
        if (core_busy_i) begin
          timer_d = '0;
          state_d = StRun;
        end else if (timer_q == BusyLast) begin
          state_d = StResp;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StRun: begin
        if (!core_busy_i || (timer_q == RunLast)) begin
          state_d = StResp;
        end else begin
          timer_d = timer_q + TimerW'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state so every port comes straight from a flop.
  always_comb begin
    req_ready_d   = (state_d == StIdle) && !core_busy_i;
    rsp_valid_d   = (state_d == StResp);
    core_load_d   = (state_d == StLoad);
    rsp_data_d    = rsp_data_q;
    rsp_timeout_d = rsp_timeout_q;
    core_key_d    = core_key_q;
    core_data_d   = core_data_q;
    done_cnt_d    = done_cnt_q;
    err_cnt_d     = err_cnt_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          core_key_d  = req_key_i;
          core_data_d = req_data_i;
        end
      end
      StWaitBusy: begin
        if (!core_busy_i && (timer_q == BusyLast)) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      StRun: begin
        if (!core_busy_i) begin
          rsp_data_d    = core_data_i;
          rsp_timeout_d = 1'b0;
        end else if (timer_q == RunLast) begin
          rsp_data_d    = '0;
          rsp_timeout_d = 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          if (rsp_timeout_q) err_cnt_d = err_cnt_q + CNT_W'(1);
          else               done_cnt_d = done_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign core_load_o   = core_load_q;
  assign core_key_o    = core_key_q;
  assign core_data_o   = core_data_q;
  assign done_cnt_o    = done_cnt_q;
  assign err_cnt_o     = err_cnt_q;

endmodule

// File: tb/tb_aes_core_sequencer.sv
// Bench for aes_core_sequencer: behavioural busy/data core model plus an in-order
// scoreboard of expected load pulses and responses.
module tb_aes_core_sequencer;

  localparam int unsigned KW = 128;
  localparam int unsigned DW = 128;
  localparam int unsigned BW = 4;
  localparam int unsigned TO = 64;
  localparam int unsigned CW = 16;
  localparam int unsigned BusyLen = 10;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          to;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [KW-1:0] req_key_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [DW-1:0] rsp_data_o;
  logic          rsp_timeout_o;
  logic          core_load_o;
  logic [KW-1:0] core_key_o;
  logic [DW-1:0] core_data_o;
  logic [DW-1:0] core_data_i;
  logic          core_busy_i;
  logic [CW-1:0] done_cnt_o;
  logic [CW-1:0] err_cnt_o;

  always #5 clk = ~clk;

  aes_core_sequencer #(
    .KEY_W(KW), .DATA_W(DW), .BUSY_WAIT(BW), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_key_i(req_key_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o),
    .core_load_o(core_load_o), .core_key_o(core_key_o), .core_data_o(core_data_o),
    .core_data_i(core_data_i), .core_busy_i(core_busy_i),
    .done_cnt_o(done_cnt_o), .err_cnt_o(err_cnt_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int load_cnt = 0;
  int mode = 0;  // 0 normal, 1 never busy, 2 busy stuck high after load

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_f(input logic [KW-1:0] k, input logic [DW-1:0] d);
    if (k == '0 && d == '0) return 128'h66E94BD4EF8A2C3B884CFA59CA342B2E;
    return d ^ {k[63:0], k[127:64]} ^ {16{8'hA5}};
  endfunction

  // Core model: busy for BusyLen cycles after a load, result valid only once busy drops.
  logic [7:0]    busy_cnt = '0;
  logic          stuck_seen = 1'b0;
  logic [KW-1:0] pend_key = '0;
  logic [DW-1:0] pend_data = '0;
  logic [DW-1:0] core_out = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (mode != 2) stuck_seen <= 1'b0;
    else if (core_load_o) stuck_seen <= 1'b1;
    if (core_load_o && mode != 1) begin
      busy_cnt  <= 8'(BusyLen);
      pend_key  <= core_key_o;
      pend_data <= core_data_o;
      core_out  <= {8{16'hDEAD}};
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 8'd1;
      if (busy_cnt == 8'd1) core_out <= model_f(pend_key, pend_data);
    end
  end

  assign core_busy_i = (busy_cnt != 0) || stuck_seen;
  assign core_data_i = core_out;

  // Scoreboard monitor, sampled on the falling edge.
  logic [255:0] load_q[$];
  rsp_t         rsp_q[$];
  logic [255:0] exp_l;
  rsp_t         exp_r;

  always @(negedge clk) begin
    if (rst_i) begin
      load_q.delete();
      rsp_q.delete();
    end else begin
      if (req_valid_i && req_ready_o) begin
        load_q.push_back({req_key_i, req_data_i});
        exp_r.data = (mode == 0) ? model_f(req_key_i, req_data_i) : '0;
        exp_r.to   = (mode != 0);
        rsp_q.push_back(exp_r);
      end
      if (core_load_o) begin
        load_cnt++;
        check("load_expected", 128'(load_q.size() != 0), 128'd1);
        if (load_q.size() != 0) begin
          exp_l = load_q.pop_front();
          check("load_key", core_key_o, exp_l[255:128]);
          check("load_data", core_data_o, exp_l[127:0]);
        end
      end
      if (rsp_valid_o && rsp_ready_i) begin
        check("rsp_expected", 128'(rsp_q.size() != 0), 128'd1);
        if (rsp_q.size() != 0) begin
          exp_r = rsp_q.pop_front();
          check("rsp_data", rsp_data_o, exp_r.data);
          check("rsp_timeout", 128'(rsp_timeout_o), 128'(exp_r.to));
        end
      end
    end
  end

  task automatic send(input logic [KW-1:0] k, input logic [DW-1:0] d);
    bit ok = 1'b0;
    req_key_i   = k;
    req_data_i  = d;
    req_valid_i = 1'b1;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready_o;
    end
    check("req_accepted", 128'(ok), 128'd1);
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    req_valid_i = 1'b0;
  endtask

  // Edges from acceptance to the first edge at which rsp_valid_o is seen high.
  task automatic wait_valid(output int lat);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid_o;
    end
    check("rsp_valid_seen", 128'(ok), 128'd1);
    lat = cyc + 1 - acc_cyc;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 128'(req_ready_o), 128'd0);
    check({tag, "_valid"}, 128'(rsp_valid_o), 128'd0);
    check({tag, "_load"}, 128'(core_load_o), 128'd0);
    check({tag, "_key"}, core_key_o, 128'd0);
    check({tag, "_cdata"}, core_data_o, 128'd0);
    check({tag, "_rdata"}, rsp_data_o, 128'd0);
    check({tag, "_timeout"}, 128'(rsp_timeout_o), 128'd0);
    check({tag, "_done"}, 128'(done_cnt_o), 128'd0);
    check({tag, "_err"}, 128'(err_cnt_o), 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int h;
    int acc;
    int loads0;
    bit ok;
    logic [DW-1:0] vals[4];
    logic [DW-1:0] exp_a;

    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    req_valid_i = 1'b1;
    rst_i       = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 128'(req_ready_o), 128'd0);
    check("load_after_reset", 128'(core_load_o), 128'd0);

    // Single request, key 0 / data 0.
    send('0, '0);
    wait_valid(lat);
    check("lat_single", 128'(lat), 128'd13);
    @(posedge clk);
    #1;
    check("done_single", 128'(done_cnt_o), 128'd1);
    check("loads_single", 128'(load_cnt), 128'd1);
    check("valid_dropped", 128'(rsp_valid_o), 128'd0);

    // Back-to-back requests.
    vals[0] = '1;
    vals[1] = '0;
    vals[2] = {16{8'hF0}};
    vals[3] = {{64{1'b1}}, {64{1'b0}}};
    loads0 = load_cnt;
    for (int i = 0; i < 4; i++) send('0, vals[i]);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = (rsp_q.size() == 0);
    end
    check("b2b_drained", 128'(ok), 128'd1);
    @(posedge clk);
    #1;
    check("done_b2b", 128'(done_cnt_o), 128'd5);
    check("loads_b2b", 128'(load_cnt - loads0), 128'd4);

    // Response back-pressure with a pending request.
    rsp_ready_i = 1'b0;
    exp_a = model_f(128'h0123456789ABCDEF0011223344556677, 128'hCAFEBABE0000FFFF1234567890ABCDEF);
    send(128'h0123456789ABCDEF0011223344556677, 128'hCAFEBABE0000FFFF1234567890ABCDEF);
    wait_valid(lat);
    check("lat_bp", 128'(lat), 128'd13);
    req_key_i   = 128'h1;
    req_data_i  = 128'h2;
    req_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", 128'(rsp_valid_o), 128'd1);
      check("bp_data", rsp_data_o, exp_a);
      check("bp_ready", 128'(req_ready_o), 128'd0);
    end
    rsp_ready_i = 1'b1;
    h  = cyc + 1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready_o;
    end
    acc = cyc + 1;
    check("bp_accept_edge", 128'(acc), 128'(h + 1));
    @(posedge clk);
    #1;
    acc_cyc     = cyc;
    req_valid_i = 1'b0;
    wait_valid(lat);
    check("lat_after_bp", 128'(lat), 128'd13);
    @(posedge clk);
    #1;
    check("done_bp", 128'(done_cnt_o), 128'd7);

    // Core never raises busy.
    mode = 1;
    send(128'h1, 128'h2);
    wait_valid(lat);
    check("lat_nobusy", 128'(lat), 128'(BW + 2));
    @(posedge clk);
    #1;
    check("err_nobusy", 128'(err_cnt_o), 128'd1);
    check("done_nobusy", 128'(done_cnt_o), 128'd7);
    mode = 0;

    // Busy stuck high after the load.
    mode = 2;
    send(128'h3, 128'h4);
    wait_valid(lat);
    check("lat_stuck", 128'(lat), 128'(TO + 3));
    @(posedge clk);
    #1;
    check("err_stuck", 128'(err_cnt_o), 128'd2);
    req_key_i   = 128'h5;
    req_data_i  = 128'h6;
    req_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ready_while_busy", 128'(req_ready_o), 128'd0);
    end
    mode = 0;
    send(128'h5, 128'h6);
    wait_valid(lat);
    check("lat_after_stuck", 128'(lat), 128'd13);
    @(posedge clk);
    #1;
    check("done_after_stuck", 128'(done_cnt_o), 128'd8);

    // Reset in the middle of RUN.
    send('0, 128'h3);
    repeat (6) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("midreset");
    rst_i = 1'b0;
    @(negedge clk);
    check("load_after_midreset", 128'(core_load_o), 128'd0);
    send(128'h7, 128'h8);
    wait_valid(lat);
    check("lat_after_reset", 128'(lat), 128'd13);
    @(posedge clk);
    #1;
    check("done_after_reset", 128'(done_cnt_o), 128'd1);
    check("err_after_reset", 128'(err_cnt_o), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
